// File: rtl/pc_fetch_pkg.sv
// Shared CPU fetch definitions: fetch FSM states, fault causes, NPC ops.
// Imported by the fetch unit, its timer and its memory-side interface.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_VALID = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_BUS      = 2'd2
    } fault_cause_e;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JAL    = 3'd2,
        NPC_JALR   = 3'd3,
        NPC_TRAP   = 3'd4
    } npc_op_e;

    localparam int unsigned XLEN = 32;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
// The fetch unit drives the request side; memory answers with ack + data.
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic            ImemReq;
    logic [XLEN-1:0] ImemAddr;
    logic            ImemAck;
    logic [XLEN-1:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemRdata
    );

endinterface

// File: rtl/fetch_timer.sv
// Ack wait counter for the fetch request; expired flags the last allowed
// cycle so the FSM can fault when that cycle also passes without an ack.
module fetch_timer
    import pc_fetch_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(ACK_TIMEOUT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = (count_q == W'(ACK_TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds one instruction at a time, refetches on
// retire, and parks in a sticky fault state on misaligned NPC or bus timeout.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [XLEN-1:0]   Npc,
    input  logic              NpcValid,
    pc_fetch_if.master        imem,
    output logic [XLEN-1:0]   Pc,
    output logic [XLEN-1:0]   Inst,
    output logic              InstValid,
    output logic              MisalignedFault,
    output logic              BusFault,
    output logic [XLEN-1:0]   InstCount
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_count_q, inst_count_d;
    logic            mis_fault_q, mis_fault_d;
    logic            bus_fault_q, bus_fault_d;
    logic            timer_expired;

    fetch_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .clk     (Clk),
        .rst     (Rst),
        .clear   (state_q != FS_REQ),
        .enable  ((state_q == FS_REQ) && !imem.ImemAck),
        .expired (timer_expired)
    );

    // Address comes from the PC register only, never straight from Npc.
    assign imem.ImemReq  = (state_q == FS_REQ);
    assign imem.ImemAddr = pc_q;

    assign Pc              = pc_q;
    assign Inst            = inst_q;
    assign InstValid       = (state_q == FS_VALID);
    assign MisalignedFault = mis_fault_q;
    assign BusFault        = bus_fault_q;
    assign InstCount       = inst_count_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_count_d = inst_count_q;
        mis_fault_d  = mis_fault_q;
        bus_fault_d  = bus_fault_q;
        unique case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
            end
            FS_REQ: begin
                if (imem.ImemAck) begin
                    inst_d  = imem.ImemRdata;
                    state_d = FS_VALID;
                end else if (timer_expired) begin
                    bus_fault_d = 1'b1;
                    state_d     = FS_FAULT;
                end
            end
            FS_VALID: begin
                if (NpcValid) begin
                    pc_d         = Npc;
                    inst_count_d = inst_count_q + 32'd1;
                    if (pc_misaligned(Npc)) begin
                        mis_fault_d = 1'b1;
                        state_d     = FS_FAULT;
                    end else begin
                        state_d = FS_REQ;
                    end
                end
            end
            FS_FAULT: begin
                state_d = FS_FAULT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_count_q <= '0;
            mis_fault_q  <= 1'b0;
            bus_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_count_q <= inst_count_d;
            mis_fault_q  <= mis_fault_d;
            bus_fault_q  <= bus_fault_d;
        end
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, default 16, is the maximum number of cycles ImemReq may wait for ImemAck before BusFault.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 Npc  input  32  next PC produced by the next-PC logic for the instruction currently held.
REQ-006 NpcValid  input  1  core has retired the held instruction; Npc is valid this cycle.
REQ-007 ImemAck  input  1  instruction memory returns ImemRdata this cycle.
REQ-008 ImemRdata  input  32  instruction word.
REQ-009 ImemReq  output  1  fetch request, held high until ImemAck.
REQ-010 ImemAddr  output  32  fetch address; equals Pc.
REQ-011 Pc  output  32  address of the held or in-flight instruction.
REQ-012 Inst  output  32  held instruction word.
REQ-013 InstValid  output  1  Inst is valid for Pc.
REQ-014 MisalignedFault  output  1  sticky; Npc[1:0] was nonzero.
REQ-015 BusFault  output  1  sticky; ImemAck timeout.
REQ-016 InstCount  output  32  number of retired instructions.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, VALID and FAULT.
REQ-018 IDLE SHALL last one cycle after reset, then go to REQ.
REQ-019 REQ: ImemReq=1, ImemAddr=Pc; ImemAck in the same cycle SHALL capture ImemRdata into Inst and go to VALID; an ack in the request's first cycle is legal.
REQ-020 VALID: InstValid=1 and ImemReq=0; Inst and Pc are held stable until NpcValid.
REQ-021 VALID with NpcValid and Npc[1:0]==0: Pc<=Npc, InstCount+=1, next state REQ, InstValid=0 in the next cycle.
REQ-022 VALID with NpcValid and Npc[1:0]!=0: InstCount+=1, Pc<=Npc, MisalignedFault<=1, next state FAULT; no request is issued.
REQ-023 REQ: a wait counter SHALL clear on entry and increment each cycle without ack; when it reaches ACK_TIMEOUT: BusFault<=1, next state FAULT.
REQ-024 FAULT SHALL be terminal until Rst: ImemReq=0, InstValid=0, and Pc and Inst frozen.
REQ-025 NpcValid outside VALID SHALL be ignored; it SHALL not change Pc or InstCount.
REQ-026 ImemAck outside REQ SHALL be ignored.
REQ-027 InstCount SHALL wrap modulo 2^32 from 32'hFFFF_FFFF to 0 without a flag.
REQ-028 Throughput SHALL be at most one instruction per 2 cycles: a zero-wait ack gives REQ, VALID, REQ, ...
REQ-029 Pc SHALL change only on reset or in VALID with NpcValid.

Reset
REQ-030 Rst SHALL force state IDLE, Pc=RESET_PC, Inst=0, InstValid=0, ImemReq=0, both faults=0, InstCount=0 and the wait counter=0.
REQ-031 Rst SHALL take priority over every other event, including Rst asserted mid-REQ with ImemAck high; the ack is discarded.

Structure
REQ-032 The state encodings (2-bit) and the FAULT cause codes SHALL live in the shared CPU defines package, alongside the NPC operation codes.
REQ-033 The ack-timeout counter SHALL be a sub-module, fetch_timer, with clear, enable and expired ports.
REQ-034 The block SHALL contain no combinational path from Npc to ImemAddr; Npc reaches ImemAddr only through the Pc register.

Verification
REQ-035 Reset then ack on the first REQ cycle with Rdata=32'h0000_0013 -> Pc=0, Inst=32'h13, InstValid=1 in the next cycle.
REQ-036 Ack delayed 5 cycles -> ImemReq held high for 6 cycles, ImemAddr stable at Pc, then InstValid=1.
REQ-037 VALID with NpcValid and Npc=32'h0000_0102 -> MisalignedFault=1, ImemReq stays 0, InstCount=1; NpcValid/ImemAck stimuli while in FAULT must leave Pc and InstCount unchanged (tests REQ-025/026).
REQ-038 No ack for 16 cycles -> BusFault=1, state FAULT; Rst then restores Pc=RESET_PC and clears BusFault.
REQ-039 Rst asserted in REQ with ImemAck=1 -> Inst=0, InstValid=0 and Pc=RESET_PC in the following cycle.
REQ-040 Preload InstCount=32'hFFFF_FFFF (force) and retire once -> InstCount=0; Pc=Npc=32'h0000_0010.
